// File: rtl/bus_arb_pkg.sv
// Shared types, constants and the round-robin winner function for the 8-way bus arbiter.
package bus_arb_pkg;

  localparam int IDX_W   = 3;
  localparam int MAX_REQ = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First set request strictly after ptr, wrapping at num_req; returns ptr when nothing is set.
  function automatic logic [IDX_W-1:0] rr_next(input logic [MAX_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr,
                                               input int                 num_req);
    logic [IDX_W-1:0] win;
    logic             found;
    int               cand;
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      cand = (int'(ptr) + k) % num_req;
      if (k <= num_req && !found && req[cand]) begin
        win   = IDX_W'(cand);
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/bus_arbiter8_rr_pick.sv
// Combinational rotate-priority selector: picks the first requester after ptr.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 8
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [MAX_REQ-1:0] req_pad;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    req_pad                = '0;
    req_pad[NUM_REQ-1:0]   = req;
  end

  assign idx = rr_next(req_pad, ptr, NUM_REQ);
  assign any = |req;

endmodule

// File: rtl/decoder3.sv
// 3-to-8 one-hot decoder.
module Decoder3 (
  input  logic [2:0] a,
  output logic [7:0] y
);

  always_comb begin
    y    = '0;
    y[a] = 1'b1;
  end

endmodule

// File: rtl/switch.sv
// Enable-gated bus driver: passes d when en is high, otherwise drives zero.
module Switch #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                 en,
  input  logic [BIT_WIDTH-1:0] d,
  output logic [BIT_WIDTH-1:0] q
);

  assign q = en ? d : '0;

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter and bus sequencer for the shared CPU data bus, with bounded tenure.
module bus_arbiter8
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ  = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic                      last,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [NUM_REQ-1:0]        grant,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      grant_valid,
  output logic [DATA_W-1:0]         bus_out,
  output logic                      timeout
);

  localparam logic [3:0]       HOLD_LAST = 4'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(NUM_REQ - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [3:0]       hold_q, hold_d;
  logic             timeout_q, timeout_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [MAX_REQ-1:0] req_pad;
  logic               at_limit;
  logic               release_now;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    req_pad              = '0;
    req_pad[NUM_REQ-1:0] = req;
  end

  assign at_limit    = (hold_q == HOLD_LAST);
  assign release_now = !req_pad[idx_q] || last || at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ptr_q     <= PTR_RST;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          idx_d   = pick_idx;
          ptr_d   = pick_idx;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          // Always pass through IDLE so two drivers never touch the bus back to back.
          state_d   = IDLE;
          timeout_d = req_pad[idx_q] && !last && at_limit;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [7:0]        dec_out;
  logic [DATA_W-1:0] sel_data;

  Decoder3 u_dec (
    .a (idx_q),
    .y (dec_out)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx_q == IDX_W'(i)) sel_data = data_in[i*DATA_W +: DATA_W];
    end
  end

  Switch #(.BIT_WIDTH(DATA_W)) u_bus (
    .en (grant_valid),
    .d  (sel_data),
    .q  (bus_out)
  );

  always_comb begin
    grant_valid = (state_q == GRANT);
    grant_idx   = idx_q;
    grant       = dec_out[NUM_REQ-1:0] & {NUM_REQ{grant_valid}};
    timeout     = timeout_q;
  end

endmodule
